// File: rtl/exe_div_sequencer.sv
// Multi-cycle signed divide/modulo sequencer for the execution stage.
// Restoring shift-subtract on magnitudes, sign fix-up, and a pipeline stall while busy.
module exe_div_sequencer #(
   parameter int unsigned W       = 32,
   parameter logic [3:0]  DIV_CMD = 4'b1100,
   parameter logic [3:0]  MOD_CMD = 4'b1101
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         flush,
   input  logic [3:0]   exe_cmd,
   input  logic [W-1:0] val1,
   input  logic [W-1:0] val2,
   output logic [W-1:0] res,
   output logic         done,
   output logic         div_zero,
   output logic         busy,
   output logic         stall
);

   localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t         state_q, state_d;
   logic [W-1:0]   rem_q, rem_d;
   logic [W-1:0]   quo_q, quo_d;
   logic [W-1:0]   dvs_q, dvs_d;
   logic [W-1:0]   res_q, res_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           qneg_q, qneg_d;
   logic           rneg_q, rneg_d;
   logic           mod_q, mod_d;
   logic           done_q, done_d;
   logic           dz_q, dz_d;
   logic           start;
   logic [W:0]     shifted;
   logic [W-1:0]   diff;

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         rem_q   <= '0;
         quo_q   <= '0;
         dvs_q   <= '0;
         res_q   <= '0;
         cnt_q   <= '0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         mod_q   <= 1'b0;
         done_q  <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvs_q   <= dvs_d;
         res_q   <= res_d;
         cnt_q   <= cnt_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         mod_q   <= mod_d;
         done_q  <= done_d;
         dz_q    <= dz_d;
      end
   end

   // Next-state, datapath update and stall
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      res_d   = res_q;
      cnt_d   = cnt_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      mod_d   = mod_q;
      done_d  = 1'b0;
      dz_d    = dz_q;

      start   = en && ((exe_cmd == DIV_CMD) || (exe_cmd == MOD_CMD)) && (state_q == IDLE);
      stall   = start || (((state_q == CALC) || (state_q == FIX)) && !flush);
      shifted = {rem_q, quo_q[W-1]};
      diff    = W'(shifted - {1'b0, dvs_q});

      unique case (state_q)
         IDLE: begin
            if (start) begin
               if (val2 == '0) begin
                  res_d   = (exe_cmd == MOD_CMD) ? val1 : {W{1'b1}};
                  dz_d    = 1'b1;
                  done_d  = 1'b1;
                  state_d = DONE;
               end else begin
                  quo_d   = val1[W-1] ? -val1 : val1;
                  dvs_d   = val2[W-1] ? -val2 : val2;
                  rem_d   = '0;
                  cnt_d   = '0;
                  qneg_d  = val1[W-1] ^ val2[W-1];
                  rneg_d  = val1[W-1];
                  mod_d   = (exe_cmd == MOD_CMD);
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            // Shifted partial remainder may need W+1 bits before the compare
            if (shifted >= {1'b0, dvs_q}) begin
               rem_d = diff;
               quo_d = {quo_q[W-2:0], 1'b1};
            end else begin
               rem_d = shifted[W-1:0];
               quo_d = {quo_q[W-2:0], 1'b0};
            end
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(W - 1)) begin
               state_d = FIX;
            end
         end
         FIX: begin
            if (mod_q) begin
               res_d = rneg_q ? -rem_q : rem_q;
            end else begin
               res_d = qneg_q ? -quo_q : quo_q;
            end
            dz_d    = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Abort discards the op without publishing a result
      if (flush) begin
         state_d = IDLE;
         done_d  = 1'b0;
         res_d   = res_q;
         dz_d    = dz_q;
      end
   end

   assign res      = res_q;
   assign done     = done_q;
   assign div_zero = dz_q;
   assign busy     = (state_q != IDLE);

endmodule
